// File: rtl/input_port_arbiter_if.sv
// Bundle of the four-port request side and the shared downstream packet path
// of the input port arbiter.
interface input_port_arbiter_if;
  logic [3:0]   iv_pkt_rdy;
  logic [535:0] iv_data;
  logic [3:0]   ov_data_rd;
  logic [123:0] iv_time_length;
  logic [3:0]   ov_time_length_rd;
  logic         i_almost_full;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [32:0]  ov_time_length;
  logic         o_time_length_wr;
  logic         o_format_err;
  logic [1:0]   ov_grant;

  modport master (
    input  iv_pkt_rdy, iv_data, iv_time_length, i_almost_full,
    output ov_data_rd, ov_time_length_rd, ov_data, o_data_wr,
           ov_time_length, o_time_length_wr, o_format_err, ov_grant
  );

  modport slave (
    output iv_pkt_rdy, iv_data, iv_time_length, i_almost_full,
    input  ov_data_rd, ov_time_length_rd, ov_data, o_data_wr,
           ov_time_length, o_time_length_wr, o_format_err, ov_grant
  );
endinterface

// File: rtl/input_port_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 134-bit packet path between
// four show-ahead input FIFOs, forwarding each packet's port-tagged descriptor.
module input_port_arbiter #(
  parameter int PORT_NUM = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    TRANS_S = 2'd1,
    DROP_S  = 2'd2
  } state_t;

  localparam logic [1:0] HEAD_TYPE = 2'b01;
  localparam logic [1:0] TAIL_TYPE = 2'b10;

  state_t       r_state;
  state_t       w_next_state;
  logic [1:0]   r_grant;
  logic         r_first;
  logic [133:0] r_data;
  logic         r_data_wr;
  logic [32:0]  r_time_length;
  logic         r_time_length_wr;
  logic         r_format_err;

  logic [133:0] w_head;
  logic [30:0]  w_desc;
  logic [1:0]   w_type;
  logic [1:0]   w_pick;
  logic         w_consume;
  logic         w_fwd;
  logic         w_bad;
  logic         w_desc_rd;
  logic [3:0]   w_data_rd;
  logic [3:0]   w_time_length_rd;

  // First ready port after the last grant, wrapping round the four ports.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] rdy, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = last + k[1:0];
      if (!found && rdy[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Select the granted port's FIFO heads.
  always_comb begin
    w_head = bus.iv_data[133:0];
    w_desc = bus.iv_time_length[30:0];
    case (r_grant)
      2'd0: begin
        w_head = bus.iv_data[133:0];
        w_desc = bus.iv_time_length[30:0];
      end
      2'd1: begin
        w_head = bus.iv_data[267:134];
        w_desc = bus.iv_time_length[61:31];
      end
      2'd2: begin
        w_head = bus.iv_data[401:268];
        w_desc = bus.iv_time_length[92:62];
      end
      default: begin
        w_head = bus.iv_data[535:402];
        w_desc = bus.iv_time_length[123:93];
      end
    endcase
  end

  assign w_type = w_head[133:132];
  assign w_pick = f_rr_pick(bus.iv_pkt_rdy, r_grant);

  // State, grant and first-word tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE_S;
      r_grant <= 2'd3;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE_S && w_next_state == TRANS_S) begin
        r_grant <= w_pick;
        r_first <= 1'b1;
      end else if (r_state == TRANS_S && w_consume) begin
        r_first <= 1'b0;
      end else begin
        r_first <= r_first;
      end
    end
  end

  // Next-state decode; a bad head that is itself a tail ends the packet at once.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE_S: begin
        if ((|bus.iv_pkt_rdy) && !bus.i_almost_full) begin
          w_next_state = TRANS_S;
        end else begin
          w_next_state = IDLE_S;
        end
      end
      TRANS_S: begin
        if (w_consume && w_type == TAIL_TYPE) begin
          w_next_state = IDLE_S;
        end else if (w_bad) begin
          w_next_state = DROP_S;
        end else begin
          w_next_state = TRANS_S;
        end
      end
      DROP_S: begin
        if (w_type == TAIL_TYPE) begin
          w_next_state = IDLE_S;
        end else begin
          w_next_state = DROP_S;
        end
      end
      default: w_next_state = IDLE_S;
    endcase
  end

  // Read strobes and forward/drop decisions for the current cycle.
  always_comb begin
    w_consume = 1'b0;
    w_fwd     = 1'b0;
    w_bad     = 1'b0;
    w_desc_rd = 1'b0;
    case (r_state)
      TRANS_S: begin
        if (!bus.i_almost_full) begin
          w_consume = 1'b1;
          if (!r_first) begin
            w_fwd = 1'b1;
          end else if (w_type == HEAD_TYPE) begin
            w_fwd     = 1'b1;
            w_desc_rd = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end else begin
          w_consume = 1'b0;
        end
      end
      DROP_S:  w_consume = 1'b1;
      default: w_consume = 1'b0;
    endcase
    w_data_rd        = w_consume ? (4'b0001 << r_grant) : 4'b0000;
    w_time_length_rd = w_desc_rd ? (4'b0001 << r_grant) : 4'b0000;
  end

  // Registered downstream outputs, one cycle behind the consume strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data           <= 134'd0;
      r_data_wr        <= 1'b0;
      r_time_length    <= 33'd0;
      r_time_length_wr <= 1'b0;
      r_format_err     <= 1'b0;
    end else begin
      r_data_wr        <= w_fwd;
      r_time_length_wr <= w_desc_rd;
      r_format_err     <= w_bad;
      if (w_fwd) begin
        r_data <= w_head;
      end else begin
        r_data <= r_data;
      end
      if (w_desc_rd) begin
        r_time_length <= {r_grant, w_desc};
      end else begin
        r_time_length <= r_time_length;
      end
    end
  end

  assign bus.ov_data_rd        = w_data_rd;
  assign bus.ov_time_length_rd = w_time_length_rd;
  assign bus.ov_data           = r_data;
  assign bus.o_data_wr         = r_data_wr;
  assign bus.ov_time_length    = r_time_length;
  assign bus.o_time_length_wr  = r_time_length_wr;
  assign bus.o_format_err      = r_format_err;
  assign bus.ov_grant          = r_grant;

endmodule

// File: tb/tb_input_port_arbiter.sv
// Randomised and directed bench for input_port_arbiter against a packet-queue
// reference model of the arbitration rules.
module tb_input_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  input_port_arbiter_if bus();

  input_port_arbiter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Environment: per-port FIFO contents, heads at index 0.
  logic [133:0] data_q [4][$];
  logic [30:0]  desc_q [4][$];
  logic [3:0]   rdy_force;
  logic [3:0]   rdy_v;
  logic         af;

  // Reference model: current packet owner and what the outputs must show.
  bit           m_busy, m_first, m_drop;
  logic [1:0]   e_grant, n_grant;
  logic         e_data_wr, n_data_wr, e_tl_wr, n_tl_wr, e_err, n_err;
  logic [133:0] e_data, n_data;
  logic [32:0]  e_tl, n_tl;
  logic [3:0]   exp_rd, exp_tlrd, a_rd, a_tlrd;

  int grant_log[$];
  int err_cnt;
  int wr_cnt;

  task automatic check_eq(input string tag, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [133:0] head_of(input int p);
    if (data_q[p].size() > 0) return data_q[p][0];
    return 134'd0;
  endfunction

  function automatic logic [30:0] desc_of(input int p);
    if (desc_q[p].size() > 0) return desc_q[p][0];
    return 31'd0;
  endfunction

  function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (int'(last) + k) % 4;
      if (r[p]) return p[1:0];
    end
    return last;
  endfunction

  task automatic drive_pins();
    logic [133:0] w;
    rdy_v = rdy_force;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < data_q[p].size(); i++) begin
        w = data_q[p][i];
        if (w[133:132] == 2'b10) rdy_v[p] = 1'b1;
      end
      bus.iv_data[134*p +: 134]       = head_of(p);
      bus.iv_time_length[31*p +: 31]  = desc_of(p);
    end
    bus.iv_pkt_rdy    = rdy_v;
    bus.i_almost_full = af;
  endtask

  task automatic push_pkt(input int p, input int n, input bit bad);
    logic [1:0]   typ;
    logic [127:0] pay;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1)  typ = 2'b10;
      else if (i == 0) typ = bad ? 2'b11 : 2'b01;
      else             typ = 2'b11;
      pay = {$urandom(), $urandom(), $urandom(), $urandom()};
      data_q[p].push_back({typ, 4'($urandom_range(0, 15)), pay});
      if (i == 0 && typ == 2'b01) desc_q[p].push_back(31'($urandom()));
    end
  endtask

  // Expected behaviour for the cycle about to be clocked, from current inputs.
  task automatic model_eval();
    logic [133:0] w;
    n_data_wr = 1'b0; n_tl_wr = 1'b0; n_err = 1'b0;
    n_data = e_data; n_tl = e_tl; n_grant = e_grant;
    exp_rd = 4'b0000; exp_tlrd = 4'b0000;
    if (!rst_n) begin
      m_busy = 1'b0; n_data = 134'd0; n_tl = 33'd0; n_grant = 2'd3;
    end else if (!m_busy) begin
      if (rdy_v != 4'b0000 && !af) begin
        n_grant = rr_next(rdy_v, e_grant);
        m_busy = 1'b1; m_first = 1'b1; m_drop = 1'b0;
      end
    end else if (m_drop || !af) begin
      w = head_of(int'(e_grant));
      exp_rd = 4'b0001 << e_grant;
      if (m_drop) begin
        if (w[133:132] == 2'b10) m_busy = 1'b0;
      end else if (m_first && w[133:132] != 2'b01) begin
        n_err = 1'b1;
        if (w[133:132] == 2'b10) m_busy = 1'b0;
        else m_drop = 1'b1;
      end else begin
        if (m_first) begin
          exp_tlrd = 4'b0001 << e_grant;
          n_tl = {e_grant, desc_of(int'(e_grant))};
          n_tl_wr = 1'b1;
        end
        n_data = w; n_data_wr = 1'b1;
        if (w[133:132] == 2'b10) m_busy = 1'b0;
      end
      m_first = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    a_rd   = bus.ov_data_rd;
    a_tlrd = bus.ov_time_length_rd;
    check_eq("data_rd", a_rd, exp_rd);
    check_eq("tl_rd", a_tlrd, exp_tlrd);
    check_eq("data_wr", bus.o_data_wr, e_data_wr);
    if (e_data_wr) check_eq("data", bus.ov_data, e_data);
    check_eq("tl_wr", bus.o_time_length_wr, e_tl_wr);
    if (e_tl_wr) check_eq("time_length", bus.ov_time_length, e_tl);
    check_eq("format_err", bus.o_format_err, e_err);
    check_eq("grant", bus.ov_grant, e_grant);
    if (bus.o_time_length_wr) grant_log.push_back(int'(bus.ov_time_length[32:31]));
    if (bus.o_format_err) err_cnt++;
    if (bus.o_data_wr) wr_cnt++;
    @(posedge clk);
    #1;
    e_data_wr = n_data_wr; e_tl_wr = n_tl_wr; e_err = n_err;
    e_data = n_data; e_tl = n_tl; e_grant = n_grant;
    for (int p = 0; p < 4; p++) begin
      if (a_rd[p] && data_q[p].size() > 0) void'(data_q[p].pop_front());
      if (a_tlrd[p] && desc_q[p].size() > 0) void'(desc_q[p].pop_front());
    end
    drive_pins();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_data_wr", bus.o_data_wr, 1'b0);
    check_eq("rst_tl_wr", bus.o_time_length_wr, 1'b0);
    check_eq("rst_err", bus.o_format_err, 1'b0);
    check_eq("rst_data", bus.ov_data, 134'd0);
    check_eq("rst_tl", bus.ov_time_length, 33'd0);
    check_eq("rst_grant", bus.ov_grant, 2'd3);
    check_eq("rst_data_rd", bus.ov_data_rd, 4'b0000);
    m_busy = 1'b0; e_data_wr = 1'b0; e_tl_wr = 1'b0; e_err = 1'b0;
    e_data = 134'd0; e_tl = 33'd0; e_grant = 2'd3;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag, input int exp_order[$]);
    check_eq({tag, "_len"}, 134'(grant_log.size()), 134'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      check_eq(tag, 134'(grant_log[i]), 134'(exp_order[i]));
  endtask

  initial begin
    int p, n, guard;
    bit busy_q;
    rst_n = 1'b1; af = 1'b0; rdy_force = 4'b0000;
    bus.iv_data = '0; bus.iv_time_length = '0;
    drive_pins();
    #2;
    do_reset();

    // Single port 1 packet of four words.
    grant_log.delete(); wr_cnt = 0;
    push_pkt(1, 4, 1'b0); drive_pins();
    repeat (8) cycle();
    check_eq("s1_words", 134'(wr_cnt), 134'd4);
    check_log("s1_order", '{1});

    // All ports continuously ready from reset: strict rotation.
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int q = 0; q < 4; q++) push_pkt(q, 2, 1'b0);
    drive_pins();
    repeat (30) cycle();
    check_log("s2_order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // Back-pressure mid-body of a port 2 packet with port 0 waiting.
    grant_log.delete();
    push_pkt(2, 6, 1'b0); drive_pins();
    repeat (3) cycle();
    push_pkt(0, 2, 1'b0); af = 1'b1; drive_pins();
    repeat (3) cycle();
    af = 1'b0; drive_pins();
    repeat (12) cycle();
    check_log("s3_order", '{2, 0});

    // Port 3 bad head (body type) followed by a tail.
    err_cnt = 0; wr_cnt = 0;
    push_pkt(3, 2, 1'b1); drive_pins();
    repeat (6) cycle();
    check_eq("s4_err_cnt", 134'(err_cnt), 134'd1);
    check_eq("s4_wr_cnt", 134'(wr_cnt), 134'd0);
    check_eq("s4_consumed", 134'(data_q[3].size()), 134'd0);

    // Reset in the middle of a port 0 packet, then port 0 wins again.
    push_pkt(0, 5, 1'b0); drive_pins();
    repeat (3) cycle();
    do_reset();
    cycle();
    check_eq("s5_first_grant", bus.ov_grant, 2'd0);
    repeat (8) cycle();

    // Head with no tail yet: port 1 keeps the path until the tail arrives.
    grant_log.delete(); err_cnt = 0;
    data_q[1].push_back({2'b01, 4'd0, 128'h1234_5678});
    desc_q[1].push_back(31'h1abc);
    rdy_force = 4'b0010;
    push_pkt(2, 2, 1'b0); drive_pins();
    repeat (2) cycle();
    rdy_force = 4'b0000; drive_pins();
    repeat (6) cycle();
    data_q[1].push_back({2'b10, 4'd3, 128'hfeed});
    drive_pins();
    repeat (8) cycle();
    check_log("s6_order", '{1, 2});
    check_eq("s6_err_cnt", 134'(err_cnt), 134'd0);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        p = $urandom_range(0, 3);
        n = $urandom_range(1, 5);
        if (data_q[p].size() < 16) push_pkt(p, n, ($urandom_range(0, 7) == 0));
      end
      af = ($urandom_range(0, 4) == 0);
      drive_pins();
      cycle();
    end
    af = 1'b0; drive_pins();
    guard = 0;
    busy_q = 1'b1;
    while (busy_q && guard < 400) begin
      cycle();
      guard++;
      busy_q = m_busy;
      for (int q = 0; q < 4; q++) if (data_q[q].size() > 0) busy_q = 1'b1;
    end
    check_eq("drain_done", 134'(busy_q), 134'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
